// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_stall_unit_if : ID/EX/MEM hazard inputs and stall controls     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_reg1_idx;
    logic [4:0]       id_reg2_idx;
    logic             id_reg1_rd_en;
    logic             id_reg2_rd_en;
    logic [4:0]       ex_reg_wr_idx;
    logic             ex_reg_wr_en;
    logic             ex_mem_rd_en;
    logic             ex_branch_taken;
    logic             dmem_wait;
    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             ex_mem_stall;
    logic             id_ex_bubble;
    logic             mem_wb_bubble;
    logic             if_id_flush;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_reg1_idx, id_reg2_idx, id_reg1_rd_en, id_reg2_rd_en,
               ex_reg_wr_idx, ex_reg_wr_en, ex_mem_rd_en, ex_branch_taken, dmem_wait,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
               mem_wb_bubble, if_id_flush, err_timeout, stall_count, flush_count
    );

    modport slave (
        input  id_reg1_idx, id_reg2_idx, id_reg1_rd_en, id_reg2_rd_en,
               ex_reg_wr_idx, ex_reg_wr_en, ex_mem_rd_en, ex_branch_taken, dmem_wait,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
               mem_wb_bubble, if_id_flush, err_timeout, stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_stall_unit : load-use / dmem-wait / branch stall+flush control |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module hazard_stall_unit #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_stall_unit_if.slave hs
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        LU_STALL = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_TIMEOUT    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             w_lu;
    logic             w_pc_stall;
    logic             w_flush;

    assign w_lu = hs.ex_mem_rd_en & hs.ex_reg_wr_en & (hs.ex_reg_wr_idx != 5'd0) &
                  ((hs.id_reg1_rd_en & (hs.id_reg1_idx == hs.ex_reg_wr_idx)) |
                   (hs.id_reg2_rd_en & (hs.id_reg2_idx == hs.ex_reg_wr_idx)));

    // Controls are purely combinational so the action lands in the same cycle;
    // gating with rst_n makes them drop the instant reset asserts.
    always_comb begin
        hs.pc_stall      = 1'b0;
        hs.if_id_stall   = 1'b0;
        hs.id_ex_stall   = 1'b0;
        hs.ex_mem_stall  = 1'b0;
        hs.id_ex_bubble  = 1'b0;
        hs.mem_wb_bubble = 1'b0;
        hs.if_id_flush   = 1'b0;
        if (rst_n) begin
            if (hs.dmem_wait) begin
                hs.pc_stall      = 1'b1;
                hs.if_id_stall   = 1'b1;
                hs.id_ex_stall   = 1'b1;
                hs.ex_mem_stall  = 1'b1;
                hs.mem_wb_bubble = 1'b1;
            end else if (hs.ex_branch_taken) begin
                hs.if_id_flush   = 1'b1;
                hs.id_ex_bubble  = 1'b1;
            end else if (w_lu) begin
                hs.pc_stall      = 1'b1;
                hs.if_id_stall   = 1'b1;
                hs.id_ex_bubble  = 1'b1;
            end
        end
    end

    assign w_pc_stall = hs.pc_stall;
    assign w_flush    = hs.if_id_flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (hs.dmem_wait)            state_d = MEM_WAIT;
                else if (hs.ex_branch_taken) state_d = FLUSH;
                else if (w_lu)               state_d = LU_STALL;
                else                         state_d = RUN;
            end
            MEM_WAIT: state_d = hs.dmem_wait ? MEM_WAIT : RUN;
            LU_STALL: state_d = RUN;
            FLUSH:    state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Watchdog parks at TIMEOUT so a very long wait cannot wrap back to zero.
    always_comb begin
        wd_d        = wd_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hs.dmem_wait) begin
            wd_d = '0;
        end else if (wd_q != c_TIMEOUT) begin
            wd_d = wd_q + 1'b1;
        end
        if (hs.dmem_wait && (wd_q == c_TIMEOUT_M1)) begin
            err_d = 1'b1;
        end
        if (w_pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (w_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wd_q        <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hs.err_timeout = err_q;
    assign hs.stall_count = stall_cnt_q;
    assign hs.flush_count = flush_cnt_q;

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side partner of the forwarding unit in the 5-stage RV32I pipeline.
- Detects hazards that forwarding cannot resolve and generates per-stage stall, bubble and flush controls:
  - load-use on EX,
  - multi-cycle data-memory wait in MEM,
  - taken branch/jump resolved in EX.
- Keeps a small state machine, a dmem-timeout watchdog and saturating performance counters.

Parameters:
- CNT_W, 16, width of each saturating performance counter
- TIMEOUT, 255, max consecutive dmem_wait cycles before err_timeout asserts (1..2^CNT_W-1)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_reg1_idx  in  5  rs1 of instruction in ID
- id_reg2_idx  in  5  rs2 of instruction in ID
- id_reg1_rd_en  in  1  ID instruction reads rs1
- id_reg2_rd_en  in  1  ID instruction reads rs2
- ex_reg_wr_idx  in  5  rd of instruction in EX
- ex_reg_wr_en  in  1  EX instruction writes rd
- ex_mem_rd_en  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- dmem_wait  in  1  MEM-stage data access not complete this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- id_ex_stall  out  1  hold ID/EX register
- ex_mem_stall  out  1  hold EX/MEM register
- id_ex_bubble  out  1  load NOP into ID/EX
- mem_wb_bubble  out  1  load NOP into MEM/WB
- if_id_flush  out  1  load NOP into IF/ID
- err_timeout  out  1  sticky watchdog error
- stall_count  out  CNT_W  cycles with pc_stall high, saturating
- flush_count  out  CNT_W  branch flush events, saturating

Behaviour:

Reset (rst_n low, asynchronous):
- State goes to RUN; counters, watchdog and err_timeout clear.
- All control outputs read 0 while reset is asserted.

Load-use hazard (lu, combinational):
- lu = ex_mem_rd_en & ex_reg_wr_en & (ex_reg_wr_idx != 0) & ((id_reg1_rd_en & id_reg1_idx == ex_reg_wr_idx) | (id_reg2_rd_en & id_reg2_idx == ex_reg_wr_idx)).

States:
- RUN
  - if dmem_wait: go to MEM_WAIT.
  - else if ex_branch_taken: go to FLUSH.
  - else if lu: go to LU_STALL.
  - else stay in RUN.
- MEM_WAIT: stay while dmem_wait; on deassert go to RUN.
- LU_STALL: one cycle, then RUN.
- FLUSH: one cycle, then RUN.

Outputs (combinational from state and inputs; same-cycle action, no extra latency):
- dmem_wait high, any state:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall all high.
  - mem_wb_bubble high.
  - All other outputs low.
  - dmem_wait has highest priority; branch and lu are ignored that cycle.
- Else ex_branch_taken:
  - if_id_flush high and id_ex_bubble high.
  - No stalls.
  - Branch beats lu, because the dependent instruction in ID is being flushed.
- Else lu:
  - pc_stall and if_id_stall high.
  - id_ex_bubble high.
- Otherwise all controls are low.

Registered state (observability only):
- The state register records the event taken in the previous cycle.
- LU_STALL does not force outputs; the bubble removes the load from EX, so lu drops naturally.
- Back-to-back lu on a new load re-stalls normally.

Watchdog:
- Counts consecutive cycles with dmem_wait high; clears when dmem_wait is low.
- When the count reaches TIMEOUT, err_timeout sets and holds until reset.
- Stall behaviour is unchanged after err_timeout sets.

Counters:
- stall_count increments on every cycle with pc_stall high.
- flush_count increments on every cycle with if_id_flush high.
- Both saturate at all-ones and never wrap.

Reset mid-stall:
- All controls drop immediately (asynchronous).
- The pipeline resumes in RUN after release.

Test Plan:
1. Reset, then ex_mem_rd_en=1, ex_reg_wr_en=1, ex_reg_wr_idx=5, id_reg1_idx=5, id_reg1_rd_en=1 for 1 cycle -> pc_stall=1, if_id_stall=1, id_ex_bubble=1; stall_count=1 after the edge. Same stimulus with ex_reg_wr_idx=0 -> no stall.
2. Load rd=7, ID rs2=7 but id_reg2_rd_en=0 -> no stall. Non-load EX (ex_mem_rd_en=0) writing rd=7 with rs2 read enabled -> no stall (forwarding covers it).
3. dmem_wait high 3 cycles while lu and ex_branch_taken are also high -> the four stalls and mem_wb_bubble are high for 3 cycles, no flush. Branch flush occurs in the cycle after dmem_wait falls; flush_count=1, stall_count=3.
4. ex_branch_taken with lu simultaneously -> if_id_flush=1, id_ex_bubble=1, pc_stall=0.
5. TIMEOUT=4, dmem_wait high 4 cycles -> err_timeout=1 and stays 1 after dmem_wait falls. rst_n pulsed low mid-wait -> all outputs 0 asynchronously, err_timeout cleared.
6. CNT_W=2, hold lu-triggering stimulus 5 cycles -> stall_count=3 and holds at 3.
